// File: rtl/memory_access_stage.sv
// -----------------------------------------------------------------------------
// memory_access_stage
//
// MEM stage of the DLX pipeline. Takes the EX/MEM pipeline register outputs,
// runs loads and stores over a multi-cycle req/ack data-memory port, holds the
// upstream pipeline while an access is outstanding, and registers the MEM/WB
// outputs (write enable, destination register, write-back data).
//
// Optional feature macro: MEM_TIMEOUT_EN
//   When defined, a wait counter aborts an access that waits TIMEOUT_CYCLES
//   cycles without an ack. The instruction completes with no register write
//   and the sticky bus_error_out flag is raised. When undefined, BUSY waits
//   indefinitely and bus_error_out is tied to 0.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   mem_data_rd_en_in        load request from EX/MEM
//   mem_data_wr_en_in        store request from EX/MEM
//   mem_data_in              store data
//   alu_data_in              ALU result (memory address or write-back value)
//   reg_wr_en_in             register write enable
//   reg_wr_addr_in           destination register
//   write_back_mux_sel_in    1 = write back load data, 0 = write back ALU data
//   dmem_req/we/addr/wdata   registered data-memory request
//   dmem_rdata, dmem_ack     load data and single-cycle completion pulse
//   stall_out                combinational hold for the upstream stages
//   reg_wr_en_out, reg_wr_addr_out, reg_wr_data_out   MEM/WB register outputs
//   bus_error_out            sticky access-timeout flag
// -----------------------------------------------------------------------------
module memory_access_stage #(
  parameter int DATA_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH  = 5,
  parameter int DMEM_ADDR_WIDTH = 20,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       mem_data_rd_en_in,
  input  logic                       mem_data_wr_en_in,
  input  logic [DATA_WIDTH-1:0]      mem_data_in,
  input  logic [DATA_WIDTH-1:0]      alu_data_in,
  input  logic                       reg_wr_en_in,
  input  logic [REG_ADDR_WIDTH-1:0]  reg_wr_addr_in,
  input  logic                       write_back_mux_sel_in,
  output logic                       dmem_req,
  output logic                       dmem_we,
  output logic [DMEM_ADDR_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0]      dmem_wdata,
  input  logic [DATA_WIDTH-1:0]      dmem_rdata,
  input  logic                       dmem_ack,
  output logic                       stall_out,
  output logic                       reg_wr_en_out,
  output logic [REG_ADDR_WIDTH-1:0]  reg_wr_addr_out,
  output logic [DATA_WIDTH-1:0]      reg_wr_data_out,
  output logic                       bus_error_out
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic access_req;
  logic start_access;
  logic finish_access;
  logic timeout_hit;
  logic timeout_won;

  logic                       dmem_req_q;
  logic                       dmem_we_q;
  logic [DMEM_ADDR_WIDTH-1:0] dmem_addr_q;
  logic [DATA_WIDTH-1:0]      dmem_wdata_q;

  logic                       hold_wr_en_q;
  logic [REG_ADDR_WIDTH-1:0]  hold_wr_addr_q;
  logic                       hold_load_sel_q;
  logic [DATA_WIDTH-1:0]      hold_alu_q;

  logic                       wb_wr_en_q;
  logic [REG_ADDR_WIDTH-1:0]  wb_wr_addr_q;
  logic [DATA_WIDTH-1:0]      wb_wr_data_q;

  assign access_req  = mem_data_rd_en_in | mem_data_wr_en_in;
  // A timeout only takes effect when no ack arrives in the same cycle.
  assign timeout_won = timeout_hit & ~dmem_ack;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (access_req) state_d = BUSY;
      BUSY: if (dmem_ack || timeout_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / strobe logic. Stall drops in the completion cycle so the
  // upstream stage advances on the same edge the FSM returns to IDLE.
  always_comb begin
    start_access  = 1'b0;
    finish_access = 1'b0;
    stall_out     = 1'b0;
    case (state_q)
      IDLE: begin
        start_access = access_req;
        stall_out    = access_req;
      end
      BUSY: begin
        finish_access = dmem_ack | timeout_hit;
        stall_out     = ~(dmem_ack | timeout_hit);
      end
      default: ;
    endcase
  end

  // Memory request registers stay stable for the whole access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
    end else if (start_access) begin
      dmem_req_q   <= 1'b1;
      dmem_we_q    <= mem_data_wr_en_in;
      dmem_addr_q  <= alu_data_in[DMEM_ADDR_WIDTH-1:0];
      dmem_wdata_q <= mem_data_in;
    end else if (finish_access) begin
      dmem_req_q   <= 1'b0;
    end
  end

  // Holding registers for the instruction in flight. A simultaneous
  // read+write is a store, so load data is never selected for it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_wr_en_q    <= 1'b0;
      hold_wr_addr_q  <= '0;
      hold_load_sel_q <= 1'b0;
      hold_alu_q      <= '0;
    end else if (start_access) begin
      hold_wr_en_q    <= reg_wr_en_in;
      hold_wr_addr_q  <= reg_wr_addr_in;
      hold_load_sel_q <= write_back_mux_sel_in & ~mem_data_wr_en_in;
      hold_alu_q      <= alu_data_in;
    end
  end

  // MEM/WB register: pass-through for non-memory ops, bubble while an
  // access is outstanding, held instruction on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_wr_en_q   <= 1'b0;
      wb_wr_addr_q <= '0;
      wb_wr_data_q <= '0;
    end else if (start_access) begin
      wb_wr_en_q   <= 1'b0;
    end else if (finish_access) begin
      wb_wr_en_q   <= hold_wr_en_q & ~timeout_won;
      wb_wr_addr_q <= hold_wr_addr_q;
      wb_wr_data_q <= (hold_load_sel_q && !timeout_won) ? dmem_rdata : hold_alu_q;
    end else if (state_q == IDLE) begin
      wb_wr_en_q   <= reg_wr_en_in;
      wb_wr_addr_q <= reg_wr_addr_in;
      wb_wr_data_q <= alu_data_in;
    end else begin
      wb_wr_en_q   <= 1'b0;
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_NEED = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W    = (CNT_NEED > 8) ? CNT_NEED : 8;

  logic [CNT_W-1:0] wait_cnt_q;
  logic             bus_error_q;

  assign timeout_hit = (state_q == BUSY) && (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES));

  // Wait counter: cleared on entry to BUSY, counts every un-acked BUSY cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
    end else if (start_access) begin
      wait_cnt_q <= '0;
    end else if (state_q == BUSY && !dmem_ack && !timeout_hit) begin
      wait_cnt_q <= wait_cnt_q + 1'b1;
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_error_q <= 1'b0;
    end else if (finish_access && timeout_won) begin
      bus_error_q <= 1'b1;
    end
  end

  assign bus_error_out = bus_error_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout_hit        = 1'b0;
  assign bus_error_out      = 1'b0;
`endif

  assign dmem_req        = dmem_req_q;
  assign dmem_we         = dmem_we_q;
  assign dmem_addr       = dmem_addr_q;
  assign dmem_wdata      = dmem_wdata_q;
  assign reg_wr_en_out   = wb_wr_en_q;
  assign reg_wr_addr_out = wb_wr_addr_q;
  assign reg_wr_data_out = wb_wr_data_q;

endmodule

// File: tb/tb_memory_access_stage.sv
// -----------------------------------------------------------------------------
// tb_memory_access_stage
//
// Directed testbench for memory_access_stage. Inputs are driven 1 time unit
// after the rising edge, combinational stall is checked 1 unit later, and
// registered outputs are checked 1 unit after each rising edge.
// With MEM_TIMEOUT_EN defined the DUT is built with TIMEOUT_CYCLES=4 and the
// timeout sequence is exercised as well.
// -----------------------------------------------------------------------------
module tb_memory_access_stage;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int AW = 20;
`ifdef MEM_TIMEOUT_EN
  localparam int TB_TIMEOUT = 4;
`else
  localparam int TB_TIMEOUT = 255;
`endif

  logic          clk;
  logic          rst_n;
  logic          rdEn;
  logic          wrEn;
  logic [DW-1:0] memData;
  logic [DW-1:0] aluData;
  logic          regWrEn;
  logic [RW-1:0] regWrAddr;
  logic          wbSel;
  logic          dmemReq;
  logic          dmemWe;
  logic [AW-1:0] dmemAddr;
  logic [DW-1:0] dmemWdata;
  logic [DW-1:0] dmemRdata;
  logic          dmemAck;
  logic          stall;
  logic          wbWrEn;
  logic [RW-1:0] wbWrAddr;
  logic [DW-1:0] wbWrData;
  logic          busError;

  int assertCount;
  int failCount;
  int stallCycles;
  int reqCycles;

  memory_access_stage #(
    .DATA_WIDTH      (DW),
    .REG_ADDR_WIDTH  (RW),
    .DMEM_ADDR_WIDTH (AW),
    .TIMEOUT_CYCLES  (TB_TIMEOUT)
  ) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .mem_data_rd_en_in     (rdEn),
    .mem_data_wr_en_in     (wrEn),
    .mem_data_in           (memData),
    .alu_data_in           (aluData),
    .reg_wr_en_in          (regWrEn),
    .reg_wr_addr_in        (regWrAddr),
    .write_back_mux_sel_in (wbSel),
    .dmem_req              (dmemReq),
    .dmem_we               (dmemWe),
    .dmem_addr             (dmemAddr),
    .dmem_wdata            (dmemWdata),
    .dmem_rdata            (dmemRdata),
    .dmem_ack              (dmemAck),
    .stall_out             (stall),
    .reg_wr_en_out         (wbWrEn),
    .reg_wr_addr_out       (wbWrAddr),
    .reg_wr_data_out       (wbWrData),
    .bus_error_out         (busError)
  );

  // 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Guard against a hung run.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Present one EX/MEM instruction.
  task automatic applyStimulus(input logic rd, input logic wr,
                               input logic [DW-1:0] mdata, input logic [DW-1:0] alu,
                               input logic wen, input logic [RW-1:0] waddr,
                               input logic sel);
    rdEn      = rd;
    wrEn      = wr;
    memData   = mdata;
    aluData   = alu;
    regWrEn   = wen;
    regWrAddr = waddr;
    wbSel     = sel;
  endtask

  task automatic nextEdge();
    @(posedge clk);
    #1;
  endtask

  // Main directed sequence.
  initial begin
    assertCount = 0;
    failCount   = 0;
    rst_n       = 1'b0;
    dmemAck     = 1'b0;
    dmemRdata   = '0;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);

    // Reset state.
    #3;
    checkOutput("rst_req",   {63'd0, dmemReq}, 64'd0);
    checkOutput("rst_wen",   {63'd0, wbWrEn}, 64'd0);
    checkOutput("rst_data",  {32'd0, wbWrData}, 64'd0);
    checkOutput("rst_stall", {63'd0, stall}, 64'd0);
    checkOutput("rst_berr",  {63'd0, busError}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nextEdge();

    // ALU op passes through in one cycle.
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0000_1234, 1'b1, 5'd7, 1'b0);
    #1 checkOutput("alu_stall", {63'd0, stall}, 64'd0);
    nextEdge();
    checkOutput("alu_wen",   {63'd0, wbWrEn}, 64'd1);
    checkOutput("alu_waddr", {59'd0, wbWrAddr}, 64'd7);
    checkOutput("alu_wdata", {32'd0, wbWrData}, 64'h1234);
    checkOutput("alu_req",   {63'd0, dmemReq}, 64'd0);

    // Load with three wait cycles.
    stallCycles = 0;
    reqCycles   = 0;
    applyStimulus(1'b1, 1'b0, 32'h0, 32'h0004_0010, 1'b1, 5'd3, 1'b1);
    #1 checkOutput("ld_stall0", {63'd0, stall}, 64'd1);
    if (stall) stallCycles++;
    nextEdge();
    checkOutput("ld_addr",   {44'd0, dmemAddr}, 64'h40010);
    checkOutput("ld_we",     {63'd0, dmemWe}, 64'd0);
    for (int w = 0; w < 3; w++) begin
      #1;
      checkOutput("ld_wait_wen", {63'd0, wbWrEn}, 64'd0);
      if (stall) stallCycles++;
      if (dmemReq) reqCycles++;
      nextEdge();
    end
    dmemAck   = 1'b1;
    dmemRdata = 32'hDEAD_BEEF;
    #1;
    checkOutput("ld_ack_stall", {63'd0, stall}, 64'd0);
    if (stall) stallCycles++;
    if (dmemReq) reqCycles++;
    nextEdge();
    dmemAck   = 1'b0;
    dmemRdata = 32'h0;
    checkOutput("ld_stall_cycles", 64'(stallCycles), 64'd4);
    checkOutput("ld_req_cycles",   64'(reqCycles), 64'd4);
    checkOutput("ld_req_drop",     {63'd0, dmemReq}, 64'd0);
    checkOutput("ld_wen",          {63'd0, wbWrEn}, 64'd1);
    checkOutput("ld_waddr",        {59'd0, wbWrAddr}, 64'd3);
    checkOutput("ld_wdata",        {32'd0, wbWrData}, 64'hDEAD_BEEF);

    // ALU op right behind the load: written once, after the load.
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0000_0077, 1'b1, 5'd12, 1'b0);
    #1 checkOutput("b2b_stall", {63'd0, stall}, 64'd0);
    nextEdge();
    checkOutput("b2b_waddr", {59'd0, wbWrAddr}, 64'd12);
    checkOutput("b2b_wdata", {32'd0, wbWrData}, 64'h77);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
    nextEdge();
    checkOutput("b2b_nodup", {63'd0, wbWrEn}, 64'd0);

    // Store with immediate ack.
    applyStimulus(1'b0, 1'b1, 32'hCAFE_F00D, 32'h0000_0200, 1'b0, 5'd4, 1'b0);
    #1 checkOutput("st_stall0", {63'd0, stall}, 64'd1);
    nextEdge();
    checkOutput("st_req",   {63'd0, dmemReq}, 64'd1);
    checkOutput("st_we",    {63'd0, dmemWe}, 64'd1);
    checkOutput("st_wdata", {32'd0, dmemWdata}, 64'hCAFE_F00D);
    checkOutput("st_addr",  {44'd0, dmemAddr}, 64'h200);
    dmemAck = 1'b1;
    #1 checkOutput("st_ack_stall", {63'd0, stall}, 64'd0);
    nextEdge();
    dmemAck = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
    checkOutput("st_req_drop", {63'd0, dmemReq}, 64'd0);
    checkOutput("st_wen",      {63'd0, wbWrEn}, 64'd0);

    // Read and write together: store, write-back of ALU data.
    applyStimulus(1'b1, 1'b1, 32'h1111_2222, 32'h0000_0055, 1'b1, 5'd9, 1'b1);
    nextEdge();
    checkOutput("rw_we", {63'd0, dmemWe}, 64'd1);
    dmemAck   = 1'b1;
    dmemRdata = 32'hFFFF_0000;
    nextEdge();
    dmemAck   = 1'b0;
    dmemRdata = 32'h0;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
    checkOutput("rw_wen",   {63'd0, wbWrEn}, 64'd1);
    checkOutput("rw_waddr", {59'd0, wbWrAddr}, 64'd9);
    checkOutput("rw_wdata", {32'd0, wbWrData}, 64'h55);

    // Stray ack while idle is ignored.
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0000_0099, 1'b1, 5'd1, 1'b0);
    dmemAck = 1'b1;
    #1 checkOutput("idle_ack_stall", {63'd0, stall}, 64'd0);
    nextEdge();
    dmemAck = 1'b0;
    checkOutput("idle_ack_req",   {63'd0, dmemReq}, 64'd0);
    checkOutput("idle_ack_wdata", {32'd0, wbWrData}, 64'h99);

    // Reset in BUSY; address truncation of a wide ALU value.
    applyStimulus(1'b1, 1'b0, 32'h0, 32'hFFF1_2345, 1'b1, 5'd6, 1'b1);
    nextEdge();
    checkOutput("rb_addr_trunc", {44'd0, dmemAddr}, 64'h12345);
    checkOutput("rb_req",        {63'd0, dmemReq}, 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("rb_req_drop", {63'd0, dmemReq}, 64'd0);
    checkOutput("rb_wen",      {63'd0, wbWrEn}, 64'd0);
    checkOutput("rb_wdata",    {32'd0, wbWrData}, 64'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
    #2 rst_n = 1'b1;
    nextEdge();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0000_0ABC, 1'b1, 5'd5, 1'b0);
    nextEdge();
    checkOutput("post_rst_wen",   {63'd0, wbWrEn}, 64'd1);
    checkOutput("post_rst_waddr", {59'd0, wbWrAddr}, 64'd5);
    checkOutput("post_rst_wdata", {32'd0, wbWrData}, 64'hABC);

`ifdef MEM_TIMEOUT_EN
    // Load that never gets an ack: aborts after four wait cycles.
    applyStimulus(1'b1, 1'b0, 32'h0, 32'h0000_0020, 1'b1, 5'd2, 1'b1);
    nextEdge();
    for (int w = 0; w < 4; w++) begin
      #1 checkOutput("to_wait_stall", {63'd0, stall}, 64'd1);
      nextEdge();
    end
    #1 checkOutput("to_fire_stall", {63'd0, stall}, 64'd0);
    nextEdge();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0000_0031, 1'b1, 5'd8, 1'b0);
    checkOutput("to_req_drop", {63'd0, dmemReq}, 64'd0);
    checkOutput("to_wen",      {63'd0, wbWrEn}, 64'd0);
    checkOutput("to_berr",     {63'd0, busError}, 64'd1);
    nextEdge();
    checkOutput("to_next_wen",  {63'd0, wbWrEn}, 64'd1);
    checkOutput("to_berr_held", {63'd0, busError}, 64'd1);
`else
    checkOutput("berr_tied", {63'd0, busError}, 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
